// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline stages (fetch, decode bubble insertion).
package mips_pkg;
  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'd0;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
    logic              valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
endpackage

// File: rtl/instruction_memory.sv
// Read-only instruction store, combinational read. The hex image is supplied as a
// packed parameter (word 0 in the low 32 bits); indices past the end read as NOP.
module instruction_memory
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [IMEM_DEPTH*WORD_W-1:0] IMEM_INIT = '0
) (
  input  logic [WORD_W-1:0] addr,
  output logic [WORD_W-1:0] rdata
);
  localparam int unsigned AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [WORD_W-1:0] rom [IMEM_DEPTH];
  logic [WORD_W-1:0] word_idx;
  logic [AW-1:0]     idx;
  logic              in_range;
  logic              unused_byte_bits;

  for (genvar i = 0; i < IMEM_DEPTH; i++) begin : g_rom
    assign rom[i] = IMEM_INIT[i*WORD_W +: WORD_W];
  end

  assign word_idx         = {2'b00, addr[WORD_W-1:2]};
  assign idx              = word_idx[AW-1:0];
  assign in_range         = word_idx < WORD_W'(IMEM_DEPTH);
  assign unused_byte_bits = ^addr[1:0];

  // No aliasing: anything past the last word is a NOP, never a wrapped index.
  assign rdata = in_range ? rom[idx] : NOP_INSTR;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// A taken branch beats a freeze in both registers so a redirect is never lost to a stall.
module if_stage
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [IMEM_DEPTH*WORD_W-1:0] IMEM_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freez,
  input  logic              branchTaken,
  input  logic [WORD_W-1:0] branchAddr,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] Instruction,
  output logic              valid
);
  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] branch_target;
  logic [WORD_W-1:0] fetched;
  ifid_t             ifid_q;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = branchAddr & ~32'h3;

  instruction_memory #(
    .IMEM_DEPTH(IMEM_DEPTH),
    .IMEM_INIT (IMEM_INIT)
  ) u_imem (
    .addr (pc_q),
    .rdata(fetched)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (branchTaken) begin
      pc_q <= branch_target;
    end else if (!freez) begin
      pc_q <= pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q <= IFID_BUBBLE;
    end else if (branchTaken) begin
      ifid_q <= IFID_BUBBLE;
    end else if (!freez) begin
      ifid_q <= '{pc: pc_plus4, instr: fetched, valid: 1'b1};
    end
  end

  assign PC          = ifid_q.pc;
  assign Instruction = ifid_q.instr;
  assign valid       = ifid_q.valid;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, freeze, branch flush,
// branch-over-freeze, out-of-range fetch, PC wrap and asynchronous reset.
module tb_if_stage;
  localparam int unsigned DEPTH = 64;
  localparam logic [DEPTH*32-1:0] IMG =
    {1920'd0, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  logic        clk = 1'b0;
  logic        rst;
  logic        freez;
  logic        branchTaken;
  logic [31:0] branchAddr;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        valid;

  int n_cmp = 0;
  int n_err = 0;

  if_stage #(
    .IMEM_DEPTH(DEPTH),
    .RESET_PC  (32'h0000_0000),
    .IMEM_INIT (IMG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .freez      (freez),
    .branchTaken(branchTaken),
    .branchAddr (branchAddr),
    .PC         (PC),
    .Instruction(Instruction),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [4] = '{32'd4, 32'd8, 32'd12, 32'd16};
    logic [31:0] exp_in [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    rst = 1'b1; freez = 1'b0; branchTaken = 1'b0; branchAddr = '0;
    #1;
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd0, 32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_immediate: got PC=%h ins=%h v=%b want 0/0/0", PC, Instruction, valid);
    end
    step(); step();
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd0, 32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_held: got PC=%h ins=%h v=%b want 0/0/0", PC, Instruction, valid);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({PC, Instruction, valid} !== {exp_pc[i], exp_in[i], 1'b1}) begin
        n_err++;
        $display("FAIL seq_fetch%0d: got PC=%h ins=%h v=%b want %h/%h/1",
                 i, PC, Instruction, valid, exp_pc[i], exp_in[i]);
      end
    end
  endtask

  task automatic test_freeze();
    // Steer back so (8, 2222_2222) sits in IF/ID, then stall it.
    branchTaken = 1'b1; branchAddr = 32'h4;
    step();
    branchTaken = 1'b0;
    step();
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd8, 32'h2222_2222, 1'b1}) begin
      n_err++;
      $display("FAIL freeze_setup: got PC=%h ins=%h v=%b want 8/22222222/1", PC, Instruction, valid);
    end
    freez = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({PC, Instruction, valid} !== {32'd8, 32'h2222_2222, 1'b1}) begin
        n_err++;
        $display("FAIL freeze_hold%0d: got PC=%h ins=%h v=%b want 8/22222222/1",
                 i, PC, Instruction, valid);
      end
    end
    freez = 1'b0;
    step();
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd12, 32'h3333_3333, 1'b1}) begin
      n_err++;
      $display("FAIL freeze_resume: got PC=%h ins=%h v=%b want c/33333333/1", PC, Instruction, valid);
    end
    step();
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd16, 32'h4444_4444, 1'b1}) begin
      n_err++;
      $display("FAIL freeze_next: got PC=%h ins=%h v=%b want 10/44444444/1", PC, Instruction, valid);
    end
  endtask

  task automatic test_branch();
    branchTaken = 1'b1; branchAddr = 32'h8;
    step();
    branchTaken = 1'b0;
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd0, 32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL branch_bubble: got PC=%h ins=%h v=%b want 0/0/0", PC, Instruction, valid);
    end
    step();
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd12, 32'h3333_3333, 1'b1}) begin
      n_err++;
      $display("FAIL branch_target: got PC=%h ins=%h v=%b want c/33333333/1", PC, Instruction, valid);
    end
  endtask

  task automatic test_branch_freeze_misaligned();
    branchTaken = 1'b1; freez = 1'b1; branchAddr = 32'h6;
    step();
    branchTaken = 1'b0; freez = 1'b0;
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd0, 32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL brfrz_bubble: got PC=%h ins=%h v=%b want 0/0/0", PC, Instruction, valid);
    end
    step();
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd8, 32'h2222_2222, 1'b1}) begin
      n_err++;
      $display("FAIL brfrz_target: got PC=%h ins=%h v=%b want 8/22222222/1", PC, Instruction, valid);
    end
  endtask

  task automatic test_out_of_range();
    branchTaken = 1'b1; branchAddr = 32'h100;
    step();
    branchTaken = 1'b0;
    step();
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'h104, 32'd0, 1'b1}) begin
      n_err++;
      $display("FAIL oor_fetch: got PC=%h ins=%h v=%b want 104/0/1", PC, Instruction, valid);
    end
  endtask

  task automatic test_pc_wrap();
    branchTaken = 1'b1; branchAddr = 32'hFFFF_FFFC;
    step();
    branchTaken = 1'b0;
    step();
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd0, 32'd0, 1'b1}) begin
      n_err++;
      $display("FAIL wrap_top: got PC=%h ins=%h v=%b want 0/0/1", PC, Instruction, valid);
    end
    step();
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd4, 32'h1111_1111, 1'b1}) begin
      n_err++;
      $display("FAIL wrap_zero: got PC=%h ins=%h v=%b want 4/11111111/1", PC, Instruction, valid);
    end
  endtask

  task automatic test_async_reset();
    step();
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd8, 32'h2222_2222, 1'b1}) begin
      n_err++;
      $display("FAIL arst_pre: got PC=%h ins=%h v=%b want 8/22222222/1", PC, Instruction, valid);
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd0, 32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL arst_immediate: got PC=%h ins=%h v=%b want 0/0/0", PC, Instruction, valid);
    end
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd4, 32'h1111_1111, 1'b1}) begin
      n_err++;
      $display("FAIL arst_restart: got PC=%h ins=%h v=%b want 4/11111111/1", PC, Instruction, valid);
    end
    step();
    n_cmp++;
    if ({PC, Instruction, valid} !== {32'd8, 32'h2222_2222, 1'b1}) begin
      n_err++;
      $display("FAIL arst_second: got PC=%h ins=%h v=%b want 8/22222222/1", PC, Instruction, valid);
    end
  endtask

  initial begin
    test_reset();
    test_freeze();
    test_branch();
    test_branch_freeze_misaligned();
    test_out_of_range();
    test_pc_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage. Holds the program counter, reads the instruction memory, and registers the fetched instruction with its PC+4 into the IF/ID pipeline register. It honours the hazard unit's freeze and the execute stage's branch-taken redirect. A taken branch flushes the IF/ID register to a NOP bubble.

## Interface
Parameters:
- IMEM_DEPTH, 64: instruction memory size in 32-bit words.
- RESET_PC, 32'h0000_0000: PC value loaded on reset; word aligned.

Ports:
- clk  in  1  single pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- freez  in  1  stall from the hazard unit; holds the PC and the IF/ID register.
- branchTaken  in  1  redirect from the execute stage.
- branchAddr  in  32  redirect target, byte address.
- PC  out  32  registered PC+4 of the instruction in IF/ID; feeds the decode stage PC input.
- Instruction  out  32  registered instruction word; feeds the decode stage.
- valid  out  1  1 when IF/ID holds a real fetched instruction; 0 for a bubble.

## Operation
- Internal `pc_q` (32 b) addresses the instruction memory at word index `pc_q[31:2]`.
- `pc_plus4 = pc_q + 4`, computed modulo 2^32. From 32'hFFFF_FFFC it wraps to 0.
- Next-PC priority, highest first:
  - branchTaken: `pc_q <= {branchAddr[31:2],2'b00}`. Misaligned low bits are dropped.
  - freez: `pc_q` holds.
  - otherwise: `pc_q <= pc_plus4`.
- IF/ID register priority, highest first:
  - branchTaken: flush, loading PC=0, Instruction=32'd0 (NOP) and valid=0.
  - freez: all three outputs hold, including valid.
  - otherwise: PC<=pc_plus4, Instruction<=imem[pc_q[31:2]], valid<=1.
- branchTaken together with freez: the branch wins in both registers, so the redirect is never lost to a stall.
- Instruction memory:
  - Combinational read; contents loaded at elaboration from a hex image.
  - A word index ≥ IMEM_DEPTH returns 32'd0 (NOP). No address aliasing.
- No write port. No state beyond `pc_q` and the IF/ID register.

## Timing
- Reset (asynchronous, immediate):
  - `pc_q`=RESET_PC.
  - PC=0, Instruction=0, valid=0.
- Fetch latency is 1 cycle: the instruction at `pc_q` appears on Instruction after the next rising edge.
- First edge after reset release (no freez, no branch): PC=RESET_PC+4, Instruction=imem[RESET_PC>>2], valid=1.
- Branch taken, sampled at edge N:
  - After edge N: IF/ID shows a bubble; `pc_q`=target.
  - After edge N+1: the target instruction is in IF/ID with PC=target+4.
- freez high for k edges: outputs stay constant for k edges. Fetch resumes at the following edge with no skipped or duplicated instruction.
- rst asserted mid-operation: all state clears asynchronously, without waiting for a clock edge. The in-flight fetch is discarded. On release, fetch restarts from RESET_PC.

## Structure
- Shared package `mips_pkg`:
  - NOP_INSTR = 32'd0.
  - WORD_W = 32.
  - Default RESET_PC.
  - Reused by the decode stage for bubble insertion.
- One sub-module: `instruction_memory`.
  - Parameter IMEM_DEPTH.
  - Input: 32-bit byte address. Output: 32-bit word.
  - Combinational read with out-of-range → NOP.
- PC register, adder, next-PC mux and IF/ID register stay in `if_stage`.

## Test plan
- **Reset / sequential fetch:**
  - Stimulus: load imem[0..3] = 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444; hold rst 2 cycles, then release.
  - Required: outputs are 0 and valid=0 during reset. Over the next 4 edges, (PC, Instruction) = (4, 1111_1111), (8, 2222_2222), (12, 3333_3333), (16, 4444_4444), all with valid=1.
- **Freeze:**
  - Stimulus: freez high for 3 edges while (PC=8, Instruction=2222_2222) is in IF/ID.
  - Required: outputs hold for those 3 edges. The next edge gives (12, 3333_3333).
- **Branch flush:**
  - Stimulus: branchTaken=1, branchAddr=32'h0000_0008 for one edge while PC=16.
  - Required: the next output is (0, 0, valid=0). The one after is (12, 3333_3333, valid=1).
- **Branch with freeze and misaligned target:**
  - Stimulus: branchTaken=1, freez=1, branchAddr=32'h0000_0006 for one edge.
  - Required: a bubble, then (8, imem[1]=2222_2222). The branch overrides the freeze.
- **Out-of-range fetch:**
  - Stimulus: IMEM_DEPTH=64; branch to 32'h0000_0100 (word index 64).
  - Required: Instruction=0, PC=32'h104, valid=1.
- **Async reset mid-run:**
  - Stimulus: assert rst between clock edges during a sequential fetch.
  - Required: outputs drop to 0 before the next edge. After release, fetch restarts at (4, imem[0]).
